// File: rtl/tdm_demuxer_1to4.sv
// Demultiplexes a bit-interleaved 32-slot TDM frame into four 8-bit channel words.
// Words are published together only once a whole frame has been received.
module tdm_demuxer_1to4 (
    input  logic       clock,
    input  logic       reset,
    input  logic       x0,
    input  logic       sync,
    output logic [7:0] z3,
    output logic [7:0] z2,
    output logic [7:0] z1,
    output logic [7:0] z0,
    output logic [3:0] s3_s0,
    output logic [1:0] b1_b0,
    output logic       valid,
    output logic       err
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t          state;
    logic [4:0]      counter;
    logic [3:0][7:0] shreg;
    logic [3:0][7:0] shreg_next;
    logic            take;
    logic [4:0]      slot;

    // A sync always restarts at slot 0, whether it opens a frame or resyncs one.
    always_comb begin
        take       = sync || (state == RECV);
        slot       = sync ? 5'd0 : counter;
        b1_b0      = take ? slot[1:0] : 2'b00;
        s3_s0      = take ? (4'b0001 << slot[1:0]) : 4'b0000;
        shreg_next = (slot == 5'd0) ? '0 : shreg;
        shreg_next[slot[1:0]][slot[4:2]] = x0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 5'd0;
            shreg   <= '0;
            z3      <= 8'h00;
            z2      <= 8'h00;
            z1      <= 8'h00;
            z0      <= 8'h00;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == RECV && sync)
                err <= 1'b1;
            if (take) begin
                shreg <= shreg_next;
                // Returning to IDLE after slot 31 lets a sync on the very next clock start a frame.
                if (slot == 5'd31) begin
                    {z3, z2, z1, z0} <= shreg_next;
                    valid            <= 1'b1;
                    state            <= IDLE;
                    counter          <= 5'd0;
                end else begin
                    state   <= RECV;
                    counter <= slot + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demuxer_1to4.sv
// Directed self-checking bench for tdm_demuxer_1to4.
// Frames are described as {z3,z2,z1,z0} and serialized here, LSB first, bit-interleaved.
module tb_tdm_demuxer_1to4;

    logic       clock;
    logic       reset;
    logic       x0;
    logic       sync;
    logic [7:0] z3, z2, z1, z0;
    logic [3:0] s3_s0;
    logic [1:0] b1_b0;
    logic       valid;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    int          vcyc[$];
    logic [31:0] vz[$];
    logic [31:0] exp_z;

    tdm_demuxer_1to4 dut (
        .clock (clock),
        .reset (reset),
        .x0    (x0),
        .sync  (sync),
        .z3    (z3),
        .z2    (z2),
        .z1    (z1),
        .z0    (z0),
        .s3_s0 (s3_s0),
        .b1_b0 (b1_b0),
        .valid (valid),
        .err   (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Records every published frame so pulse count and spacing can be checked later.
    always @(negedge clock) begin
        if (valid) begin
            vcyc.push_back(cycle);
            vz.push_back({z3, z2, z1, z0});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic x, input logic s);
        @(negedge clock);
        x0   = x;
        sync = s;
        #1;
    endtask

    task automatic send_slots(input logic [31:0] w, input int first, input int last);
        for (int k = first; k <= last; k++)
            drive(w[(k % 4) * 8 + k / 4], k == 0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        x0    = 1'b0;
        sync  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if ({z3, z2, z1, z0} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_z: got %h expected 00000000", {z3, z2, z1, z0});
        end
        n_checks++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b err=%b expected 0 0", valid, err);
        end
        n_checks++;
        if (s3_s0 !== 4'b0000 || b1_b0 !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_enables: got s=%b b=%b expected 0000 00", s3_s0, b1_b0);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_frame;
        int base;
        base  = vz.size();
        exp_z = {8'h01, 8'hFF, 8'h3C, 8'hA5};
        send_slots(exp_z, 0, 31);
        drive(1'b0, 1'b0);
        n_checks++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_valid: got %b expected 1", valid);
        end
        n_checks++;
        if ({z3, z2, z1, z0} !== exp_z) begin
            n_fail++;
            $display("FAIL single_words: got %h expected %h", {z3, z2, z1, z0}, exp_z);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err: got %b expected 0", err);
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_valid_drop: got %b expected 0", valid);
        end
        n_checks++;
        if (vz.size() !== base + 1) begin
            n_fail++;
            $display("FAIL single_pulse_count: got %0d expected %0d", vz.size() - base, 1);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [31:0] f1, f2;
        base = vz.size();
        f1   = {8'h33, 8'h22, 8'h11, 8'h00};
        f2   = {8'h77, 8'h66, 8'h55, 8'h44};
        send_slots(f1, 0, 31);
        send_slots(f2, 0, 31);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        exp_z = f2;
        n_checks++;
        if (vz.size() !== base + 2) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d expected 2", vz.size() - base);
        end else begin
            n_checks++;
            if (vz[base] !== f1) begin
                n_fail++;
                $display("FAIL b2b_frame1: got %h expected %h", vz[base], f1);
            end
            n_checks++;
            if (vz[base + 1] !== f2) begin
                n_fail++;
                $display("FAIL b2b_frame2: got %h expected %h", vz[base + 1], f2);
            end
            n_checks++;
            if (vcyc[base + 1] - vcyc[base] !== 32) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d expected 32", vcyc[base + 1] - vcyc[base]);
            end
        end
        n_checks++;
        if ({z3, z2, z1, z0} !== f2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h err=%b expected %h err=0", {z3, z2, z1, z0}, err, f2);
        end
    endtask

    task automatic test_idle_noise;
        int base;
        int bad;
        base = vz.size();
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            drive(i[0], 1'b0);
            if (s3_s0 !== 4'b0000 || b1_b0 !== 2'b00)
                bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL noise_enables: got %0d active cycles expected 0", bad);
        end
        n_checks++;
        if (vz.size() !== base || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL noise_valid: got %0d pulses expected 0", vz.size() - base);
        end
        n_checks++;
        if ({z3, z2, z1, z0} !== exp_z) begin
            n_fail++;
            $display("FAIL noise_hold: got %h expected %h", {z3, z2, z1, z0}, exp_z);
        end
    endtask

    task automatic test_slot_enables;
        logic [31:0] f;
        int bad;
        bad = 0;
        f   = {8'h9A, 8'h78, 8'h56, 8'h34};
        for (int k = 0; k < 32; k++) begin
            drive(f[(k % 4) * 8 + k / 4], k == 0);
            if (s3_s0 !== (4'b0001 << (k % 4)) || b1_b0 !== 2'(k % 4)) begin
                bad++;
                $display("FAIL enables_slot%0d: got s=%b b=%b expected s=%b b=%0d",
                         k, s3_s0, b1_b0, 4'b0001 << (k % 4), k % 4);
            end
        end
        n_checks++;
        if (bad !== 0) n_fail++;
        drive(1'b0, 1'b0);
        exp_z = f;
        n_checks++;
        if ({z3, z2, z1, z0} !== f || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL enables_frame: got %h valid=%b expected %h valid=1", {z3, z2, z1, z0}, valid, f);
        end
    endtask

    task automatic test_resync;
        int base;
        logic [31:0] junk, fnew;
        base = vz.size();
        junk = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fnew = {8'hE7, 8'h5A, 8'h96, 8'hC3};
        send_slots(junk, 0, 12);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL resync_err_before: got %b expected 0", err);
        end
        drive(fnew[0], 1'b1);
        n_checks++;
        if (s3_s0 !== 4'b0001 || b1_b0 !== 2'b00) begin
            n_fail++;
            $display("FAIL resync_enables: got s=%b b=%b expected 0001 00", s3_s0, b1_b0);
        end
        send_slots(fnew, 1, 1);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_err_set: got %b expected 1", err);
        end
        n_checks++;
        if ({z3, z2, z1, z0} !== exp_z) begin
            n_fail++;
            $display("FAIL resync_hold: got %h expected %h", {z3, z2, z1, z0}, exp_z);
        end
        send_slots(fnew, 2, 31);
        drive(1'b0, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || {z3, z2, z1, z0} !== fnew) begin
            n_fail++;
            $display("FAIL resync_frame: got %h valid=%b expected %h valid=1", {z3, z2, z1, z0}, valid, fnew);
        end
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_err_sticky: got %b expected 1", err);
        end
        n_checks++;
        if (vz.size() !== base + 1) begin
            n_fail++;
            $display("FAIL resync_pulse_count: got %0d expected 1", vz.size() - base);
        end
        exp_z = fnew;
    endtask

    task automatic test_reset_midframe;
        int base;
        logic [31:0] f;
        // The sync issued at the end of the previous task left a partial frame running.
        send_slots({8'h01, 8'h02, 8'h03, 8'h04}, 0, 19);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({z3, z2, z1, z0} !== 32'h0 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got z=%h valid=%b err=%b expected 00000000 0 0",
                     {z3, z2, z1, z0}, valid, err);
        end
        @(negedge clock);
        reset = 1'b0;
        base  = vz.size();
        for (int i = 0; i < 16; i++) drive(i[1], 1'b0);
        n_checks++;
        if (vz.size() !== base || {z3, z2, z1, z0} !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_no_valid: got %0d pulses z=%h expected 0 00000000", vz.size() - base, {z3, z2, z1, z0});
        end
        f = {8'h78, 8'h56, 8'h34, 8'h12};
        send_slots(f, 0, 31);
        drive(1'b0, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || {z3, z2, z1, z0} !== f || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_frame: got %h valid=%b err=%b expected %h 1 0", {z3, z2, z1, z0}, valid, err, f);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_idle_noise;
        test_slot_enables;
        test_resync;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demuxer_1to4.md
TDM_DEMUXER_1TO4 -- requirements
Module: tdm_demuxer_1to4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Port: clock  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears all state.
REQ-004 Port: x0  in  1  serial line from the shared bus, one TDM slot per clock.
REQ-005 Port: sync  in  1  frame marker; high marks the current x0 as slot 0.
REQ-006 Port: z3  out  8  last complete word for channel 3.
REQ-007 Port: z2  out  8  last complete word for channel 2.
REQ-008 Port: z1  out  8  last complete word for channel 1.
REQ-009 Port: z0  out  8  last complete word for channel 0.
REQ-010 Port: s3_s0  out  4  one-hot enable of the channel receiving the current sample; 0000 when no sample is taken.
REQ-011 Port: b1_b0  out  2  encoded index of the channel receiving the current sample.
REQ-012 Port: valid  out  1  one-cycle pulse; z3..z0 were updated this cycle.
REQ-013 Port: err  out  1  sticky framing error.

Function
REQ-014 Frame format SHALL be 32 consecutive slots, bit-interleaved, one slot per clock.
REQ-015 Slot k SHALL carry bit k/4 (integer division) of channel k mod 4.
REQ-016 Each channel word SHALL be sent LSB first, so slots 0..3 carry bit 0 of channels 0..3.
REQ-017 The FSM SHALL have two states: IDLE and RECV, with a 5-bit slot counter.
REQ-018 In IDLE with sync=1, x0 SHALL be sampled as slot 0, the counter SHALL become 1 and the FSM SHALL go to RECV.
REQ-019 In IDLE with sync=0, x0 SHALL be ignored.
REQ-020 In RECV, x0 SHALL be sampled into the channel given by counter[1:0], and the counter SHALL increment.
REQ-021 When slot 31 is sampled, the FSM SHALL return to IDLE, so that a sync in the next cycle starts a new frame with no gap.
REQ-022 On the clock edge that samples slot 31, z3..z0 SHALL load all four assembled words, including the slot-31 bit.
REQ-023 valid SHALL be 1 in the cycle after slot 31 is sampled, and 0 otherwise.
REQ-024 z3..z0 SHALL hold their values until the next complete frame.
REQ-025 Partial frames SHALL never update z3..z0.
REQ-026 In RECV, sync=1 at any slot other than 0 SHALL set err=1.
REQ-027 That same sample SHALL be taken as slot 0 of a new frame: counter becomes 1, partial data is discarded and no valid pulse is issued.
REQ-028 err SHALL remain 1 until reset; sync=1 in IDLE SHALL never set err.
REQ-029 s3_s0 and b1_b0 SHALL be combinational.
REQ-030 In RECV, b1_b0 SHALL equal counter[1:0] and s3_s0 SHALL be its one-hot decode.
REQ-031 In IDLE with sync=1, s3_s0 SHALL be 0001 and b1_b0 SHALL be 00.
REQ-032 In IDLE with sync=0, s3_s0 SHALL be 0000 and b1_b0 SHALL be 00.
REQ-033 In RECV with sync=1 (resync), s3_s0 SHALL be 0001 and b1_b0 SHALL be 00.

Reset
REQ-034 Reset assertion SHALL immediately force IDLE, counter=0, the shift registers to 0, z3..z0=00h, valid=0 and err=0, independent of clock.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame, and no valid SHALL follow.
REQ-036 After reset deasserts, the first frame SHALL require a sync.

Verification
REQ-037 Scenario: sync pulse at slot 0, then 32 slots encoding z0=A5h, z1=3Ch, z2=FFh, z3=01h -> valid pulses once, one cycle after slot 31, with exactly these words and err=0.
REQ-038 Scenario: two back-to-back frames (second sync in the cycle after slot 31) carrying 00h/11h/22h/33h then 44h/55h/66h/77h -> two valid pulses 32 cycles apart, and the outputs update to each frame in turn.
REQ-039 Scenario: sync again at slot 13 of a frame -> err=1 and stays 1; the old z values are held; the following 32 slots yield a valid frame with correct words.
REQ-040 Scenario: reset asserted at slot 20 of a frame -> z3..z0=00h immediately and no valid pulse; a subsequent frame decodes correctly.
REQ-041 Scenario: x0 toggling with sync=0 for 100 cycles -> no valid pulse, s3_s0=0000 and the outputs are unchanged.
REQ-042 Scenario: during a frame, monitor s3_s0 per slot -> the sequence is 0001, 0010, 0100, 1000 repeated 8 times, with b1_b0 matching.
